// File: rtl/store_check_monitor.sv
// store_check_monitor: watches the store bus (MemWriteM/DataAdrM/WriteData)
// and checks it against a table of expected stores. Sequence mode checks the
// stores in order. Tohost mode waits for a single store to a chosen entry.
module store_check_monitor #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TIMEOUT  = 1000,
  parameter logic [31:0] WIN_BASE = 32'h0000_0000,
  parameter logic [31:0] WIN_MASK = 32'hFFFF_FF00
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mode,
  input  logic                       exp_we,
  input  logic [$clog2(DEPTH)-1:0]   exp_idx,
  input  logic [ADDR_W-1:0]          exp_addr,
  input  logic [DATA_W-1:0]          exp_data,
  input  logic [$clog2(DEPTH):0]     num_exp,
  input  logic                       start,
  input  logic                       MemWriteM,
  input  logic [ADDR_W-1:0]          DataAdrM,
  input  logic [DATA_W-1:0]          WriteData,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic [1:0]                 err_code,
  output logic [$clog2(DEPTH):0]     match_cnt,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic [ADDR_W-1:0]          fail_addr,
  output logic [DATA_W-1:0]          fail_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned MW    = IDX_W + 1;
  localparam logic [ADDR_W-1:0] LP_WIN_BASE   = ADDR_W'(WIN_BASE);
  localparam logic [ADDR_W-1:0] LP_WIN_MASK   = ADDR_W'(WIN_MASK);
  localparam logic [CNT_W-1:0]  LP_LAST_CYCLE = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t              r_state;
  logic                r_mode;
  logic [MW-1:0]       r_num_exp;
  logic                r_busy, r_done, r_pass, r_fail;
  logic [1:0]          r_err_code;
  logic [MW-1:0]       r_match_cnt;
  logic [CNT_W-1:0]    r_cycle_cnt;
  logic [ADDR_W-1:0]   r_fail_addr;
  logic [DATA_W-1:0]   r_fail_data;

  logic [ADDR_W-1:0]   r_tab_addr [DEPTH];
  logic [DATA_W-1:0]   r_tab_data [DEPTH];

  logic                w_store;
  logic [IDX_W-1:0]    w_seq_idx, w_th_idx;
  logic                w_seq_addr_eq, w_seq_data_eq;
  logic                w_th_addr_eq, w_th_data_eq;
  logic                w_seq_ok, w_seq_err, w_th_pass, w_th_fail;
  logic                w_pass_now;
  logic [1:0]          w_seq_err_code;
  logic [MW-1:0]       w_match_nxt;

  // Store qualification and comparisons against the table
  assign w_store        = MemWriteM && ((DataAdrM & LP_WIN_MASK) == (LP_WIN_BASE & LP_WIN_MASK));
  assign w_seq_idx      = r_match_cnt[IDX_W-1:0];
  assign w_th_idx       = r_num_exp[IDX_W-1:0];
  assign w_seq_addr_eq  = (DataAdrM == r_tab_addr[w_seq_idx]);
  assign w_seq_data_eq  = (WriteData == r_tab_data[w_seq_idx]);
  assign w_th_addr_eq   = (DataAdrM == r_tab_addr[w_th_idx]);
  assign w_th_data_eq   = (WriteData == r_tab_data[w_th_idx]);
  assign w_seq_ok       = w_store && !r_mode && w_seq_addr_eq && w_seq_data_eq;
  assign w_seq_err      = w_store && !r_mode && !(w_seq_addr_eq && w_seq_data_eq);
  assign w_seq_err_code = w_seq_addr_eq ? 2'd1 : 2'd2;
  assign w_th_pass      = w_store && r_mode && w_th_addr_eq && w_th_data_eq;
  assign w_th_fail      = w_store && r_mode && w_th_addr_eq && !w_th_data_eq;
  assign w_match_nxt    = r_match_cnt + MW'(1);
  assign w_pass_now     = (w_seq_ok && (w_match_nxt == r_num_exp)) || w_th_pass;

  // Expected-store table: survives reset, frozen while a run is in progress
  always_ff @(posedge clk) begin
    if (exp_we && (r_state != S_RUN)) begin
      r_tab_addr[exp_idx] <= exp_addr;
      r_tab_data[exp_idx] <= exp_data;
    end
  end

  // Run control FSM with registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_num_exp   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_err_code  <= 2'd0;
      r_match_cnt <= '0;
      r_cycle_cnt <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_seq_ok || w_th_pass) begin
            r_match_cnt <= w_match_nxt;
          end
          if (w_pass_now) begin
            r_state <= S_PASS;
            r_busy  <= 1'b0;
            r_pass  <= 1'b1;
            r_done  <= 1'b1;
          end else if (w_seq_err || w_th_fail) begin
            r_state     <= S_FAIL;
            r_busy      <= 1'b0;
            r_fail      <= 1'b1;
            r_done      <= 1'b1;
            r_err_code  <= w_seq_err ? w_seq_err_code : 2'd1;
            r_fail_addr <= DataAdrM;
            r_fail_data <= WriteData;
          end else if (r_cycle_cnt == LP_LAST_CYCLE) begin
            // Timeout leaves fail_addr/fail_data at the zero set on entry
            r_state    <= S_FAIL;
            r_busy     <= 1'b0;
            r_fail     <= 1'b1;
            r_done     <= 1'b1;
            r_err_code <= 2'd3;
          end else begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (start) begin
            r_mode      <= mode;
            r_num_exp   <= num_exp;
            r_match_cnt <= '0;
            r_cycle_cnt <= '0;
            r_err_code  <= 2'd0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_fail      <= 1'b0;
            if (!mode && (num_exp == '0)) begin
              // Nothing to wait for: an empty sequence passes at once
              r_state <= S_PASS;
              r_busy  <= 1'b0;
              r_pass  <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_pass  <= 1'b0;
              r_done  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign err_code  = r_err_code;
  assign match_cnt = r_match_cnt;
  assign cycle_cnt = r_cycle_cnt;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;

endmodule

// File: tb/tb_store_check_monitor.sv
// Directed bench for store_check_monitor (TIMEOUT shortened to 20).
module tb_store_check_monitor;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 20;
  localparam int unsigned IDX_W   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              mode;
  logic              exp_we;
  logic [IDX_W-1:0]  exp_idx;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic [IDX_W:0]    num_exp;
  logic              start;
  logic              MemWriteM;
  logic [ADDR_W-1:0] DataAdrM;
  logic [DATA_W-1:0] WriteData;
  logic              busy, done, pass, fail;
  logic [1:0]        err_code;
  logic [IDX_W:0]    match_cnt;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  store_check_monitor #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W),
    .TIMEOUT(TIMEOUT), .WIN_BASE(32'h0000_0000), .WIN_MASK(32'hFFFF_FF00)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .exp_we(exp_we), .exp_idx(exp_idx),
    .exp_addr(exp_addr), .exp_data(exp_data), .num_exp(num_exp), .start(start),
    .MemWriteM(MemWriteM), .DataAdrM(DataAdrM), .WriteData(WriteData),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .err_code(err_code),
    .match_cnt(match_cnt), .cycle_cnt(cycle_cnt),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic wr(input logic [IDX_W-1:0] idx, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_we = 1'b1; exp_idx = idx; exp_addr = a; exp_data = d;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic start_run(input logic m, input logic [IDX_W:0] n);
    mode = m; num_exp = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    MemWriteM = 1'b1; DataAdrM = a; WriteData = d;
    tick();
    MemWriteM = 1'b0;
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; mode = 1'b0; exp_we = 1'b0; exp_idx = '0; exp_addr = '0;
    exp_data = '0; num_exp = '0; start = 1'b0; MemWriteM = 1'b0;
    DataAdrM = '0; WriteData = '0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_pass", 64'(pass), 0);
    check("rst_fail", 64'(fail), 0);
    check("rst_err", 64'(err_code), 0);
    check("rst_match", 64'(match_cnt), 0);
    check("rst_cycle", 64'(cycle_cnt), 0);
    check("rst_faddr", 64'(fail_addr), 0);
    reset = 1'b1;
    tick();

    wr(3'd0, 32'h10, 32'h5);
    wr(3'd1, 32'h14, 32'h6);
    wr(3'd2, 32'h18, 32'h7);

    // Full ordered sequence passes
    start_run(1'b0, 4'd3);
    check("seq_busy", 64'(busy), 1);
    check("seq_cycle0", 64'(cycle_cnt), 0);
    store(32'h10, 32'h5);
    check("seq_match1", 64'(match_cnt), 1);
    store(32'h14, 32'h6);
    store(32'h18, 32'h7);
    check("seq_pass", 64'(pass), 1);
    check("seq_done", 64'(done), 1);
    check("seq_busy_off", 64'(busy), 0);
    check("seq_match3", 64'(match_cnt), 3);
    check("seq_err", 64'(err_code), 0);
    repeat (3) tick();
    check("seq_pass_hold", 64'(pass), 1);

    // Data mismatch on the second store
    start_run(1'b0, 4'd3);
    check("dm_pass_clr", 64'(pass), 0);
    store(32'h10, 32'h5);
    store(32'h14, 32'h9);
    check("dm_fail", 64'(fail), 1);
    check("dm_err", 64'(err_code), 1);
    check("dm_faddr", 64'(fail_addr), 64'h14);
    check("dm_fdata", 64'(fail_data), 64'h9);
    check("dm_match", 64'(match_cnt), 1);

    // Address mismatch on the first store
    start_run(1'b0, 4'd3);
    check("am_fail_clr", 64'(fail), 0);
    store(32'h18, 32'h7);
    check("am_fail", 64'(fail), 1);
    check("am_err", 64'(err_code), 2);
    check("am_faddr", 64'(fail_addr), 64'h18);
    check("am_match", 64'(match_cnt), 0);

    // Out-of-window store is ignored
    start_run(1'b0, 4'd3);
    store(32'h10, 32'h5);
    store(32'h1000, 32'hDEAD);
    check("win_busy", 64'(busy), 1);
    check("win_match", 64'(match_cnt), 1);
    store(32'h14, 32'h6);
    store(32'h18, 32'h7);
    check("win_pass", 64'(pass), 1);
    check("win_match3", 64'(match_cnt), 3);

    // Reset mid-run, then a complete run with the table intact
    start_run(1'b0, 4'd3);
    store(32'h10, 32'h5);
    check("mr_match1", 64'(match_cnt), 1);
    reset = 1'b0;
    #2;
    check("mr_busy", 64'(busy), 0);
    check("mr_match0", 64'(match_cnt), 0);
    check("mr_cycle0", 64'(cycle_cnt), 0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("mr_idle_done", 64'(done), 0);
    check("mr_idle_busy", 64'(busy), 0);
    start_run(1'b0, 4'd3);
    store(32'h10, 32'h5);
    store(32'h14, 32'h6);
    store(32'h18, 32'h7);
    check("mr_rerun_pass", 64'(pass), 1);
    check("mr_rerun_match", 64'(match_cnt), 3);

    // Empty sequence passes straight away
    start_run(1'b0, 4'd0);
    check("empty_pass", 64'(pass), 1);
    check("empty_busy", 64'(busy), 0);
    check("empty_cycle", 64'(cycle_cnt), 0);

    // Timeout with no stores
    start_run(1'b0, 4'd3);
    repeat (19) tick();
    check("to_busy19", 64'(busy), 1);
    check("to_cycle19", 64'(cycle_cnt), 19);
    tick();
    check("to_fail", 64'(fail), 1);
    check("to_err", 64'(err_code), 3);
    check("to_cycle", 64'(cycle_cnt), 19);
    check("to_faddr", 64'(fail_addr), 0);
    check("to_fdata", 64'(fail_data), 0);

    // Tohost: matching store on the timeout cycle wins
    wr(3'd2, 32'h40, 32'h1);
    start_run(1'b1, 4'd2);
    store(32'h10, 32'h5);
    check("th_ignore_busy", 64'(busy), 1);
    repeat (18) tick();
    check("th_cycle19", 64'(cycle_cnt), 19);
    store(32'h40, 32'h1);
    check("th_pass", 64'(pass), 1);
    check("th_fail", 64'(fail), 0);
    check("th_err", 64'(err_code), 0);

    // Tohost: table write during RUN is ignored, wrong data fails
    start_run(1'b1, 4'd2);
    exp_we = 1'b1; exp_idx = 3'd2; exp_addr = 32'h40; exp_data = 32'h2;
    tick();
    exp_we = 1'b0;
    start = 1'b1;
    store(32'h40, 32'h2);
    start = 1'b0;
    check("thf_fail", 64'(fail), 1);
    check("thf_err", 64'(err_code), 1);
    check("thf_faddr", 64'(fail_addr), 64'h40);
    check("thf_fdata", 64'(fail_data), 64'h2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
